// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings and widths for the external memory bus arbiter.
// The owner codes are one-hot and double as the grant vector.
package mem_bus_arbiter_pkg;

  localparam int MEM_ADDR_W = 23;
  localparam int MEM_DATA_W = 16;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2,
    ARB_TURN = 2'd3
  } arb_state_e;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_P0   = 2'b01;
  localparam logic [1:0] OWNER_P1   = 2'b10;

endpackage

// File: rtl/mem_pin_mux.sv
// Selects the current owner's memory pin drives.
// Without an owner, every pin goes to its released level.
module mem_pin_mux
  import mem_bus_arbiter_pkg::*;
(
  input  logic [1:0]            owner_i,
  input  logic                  m0_ce_n_i,
  input  logic                  m0_oe_n_i,
  input  logic                  m0_we_n_i,
  input  logic [MEM_ADDR_W-1:0] m0_addr_i,
  input  logic [MEM_DATA_W-1:0] m0_dout_i,
  input  logic                  m1_ce_n_i,
  input  logic                  m1_oe_n_i,
  input  logic                  m1_we_n_i,
  input  logic [MEM_ADDR_W-1:0] m1_addr_i,
  input  logic [MEM_DATA_W-1:0] m1_dout_i,
  output logic                  ram_ce_n_o,
  output logic                  pcm_ce_n_o,
  output logic                  mem_oe_n_o,
  output logic                  mem_we_n_o,
  output logic [MEM_ADDR_W-1:0] mem_addr_o,
  output logic [MEM_DATA_W-1:0] mem_dout_o
);

  always_comb begin
    ram_ce_n_o = 1'b1;
    pcm_ce_n_o = 1'b1;
    mem_oe_n_o = 1'b1;
    mem_we_n_o = 1'b1;
    mem_addr_o = '0;
    mem_dout_o = '0;
    case (owner_i)
      OWNER_P0: begin
        ram_ce_n_o = m0_ce_n_i;
        mem_oe_n_o = m0_oe_n_i;
        mem_we_n_o = m0_we_n_i;
        mem_addr_o = m0_addr_i;
        mem_dout_o = m0_dout_i;
      end
      OWNER_P1: begin
        pcm_ce_n_o = m1_ce_n_i;
        mem_oe_n_o = m1_oe_n_i;
        mem_we_n_o = m1_we_n_i;
        mem_addr_o = m1_addr_i;
        mem_dout_o = m1_dout_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-port round-robin owner of the external memory pins (port 0 PSRAM, port 1 PCM),
// with idle turnaround between owners and forced revoke of hung owners.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int TURN_CYCLES = 2,
  parameter int HOLD_MAX    = 1024,
  parameter int HOLD_W      = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req,
  input  logic                  m1_req,
  output logic                  m0_gnt,
  output logic                  m1_gnt,
  input  logic                  m0_ce_n,
  input  logic                  m0_oe_n,
  input  logic                  m0_we_n,
  input  logic [MEM_ADDR_W-1:0] m0_addr,
  input  logic [MEM_DATA_W-1:0] m0_dout,
  input  logic                  m1_ce_n,
  input  logic                  m1_oe_n,
  input  logic                  m1_we_n,
  input  logic [MEM_ADDR_W-1:0] m1_addr,
  input  logic [MEM_DATA_W-1:0] m1_dout,
  output logic                  ram_ce_n,
  output logic                  pcm_ce_n,
  output logic                  mem_oe_n,
  output logic                  mem_we_n,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [MEM_DATA_W-1:0] mem_dout,
  output logic [1:0]            owner,
  output logic                  timeout
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);
  localparam logic [HOLD_W-1:0] TURN_LAST = HOLD_W'(TURN_CYCLES - 1);
  localparam logic [HOLD_W-1:0] CNT_ONE   = HOLD_W'(1);

  arb_state_e        state_q, state_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [1:0]        owner_q, owner_d;
  logic [1:0]        block_q, block_d;
  logic              last_q, last_d;
  logic              timeout_q, timeout_d;
  logic [1:0]        req;
  logic [1:0]        elig;
  logic              cur;

  assign req  = {m1_req, m0_req};
  // A port revoked while still requesting stays masked until it lets go once.
  assign elig = req & ~block_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    last_d    = last_q;
    timeout_d = 1'b0;
    block_d   = block_q & req;
    cur       = (state_q == ARB_OWN1);
    case (state_q)
      ARB_IDLE: begin
        if (elig[0] && (!elig[1] || last_q)) begin
          state_d = ARB_OWN0;
          owner_d = OWNER_P0;
        end else if (elig[1]) begin
          state_d = ARB_OWN1;
          owner_d = OWNER_P1;
        end
      end
      ARB_OWN0, ARB_OWN1: begin
        if (!req[cur] || cnt_q == HOLD_LAST) begin
          state_d = ARB_TURN;
          owner_d = OWNER_NONE;
          cnt_d   = '0;
          last_d  = cur;
          if (req[cur]) begin
            timeout_d    = 1'b1;
            block_d[cur] = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ARB_TURN: begin
        if (cnt_q == TURN_LAST) begin
          state_d = ARB_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARB_IDLE;
      cnt_q     <= '0;
      owner_q   <= OWNER_NONE;
      block_q   <= '0;
      last_q    <= 1'b1;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      block_q   <= block_d;
      last_q    <= last_d;
      timeout_q <= timeout_d;
    end
  end

  assign m0_gnt  = owner_q[0];
  assign m1_gnt  = owner_q[1];
  assign owner   = owner_q;
  assign timeout = timeout_q;

  mem_pin_mux u_pin_mux (
    .owner_i    (owner_q),
    .m0_ce_n_i  (m0_ce_n),
    .m0_oe_n_i  (m0_oe_n),
    .m0_we_n_i  (m0_we_n),
    .m0_addr_i  (m0_addr),
    .m0_dout_i  (m0_dout),
    .m1_ce_n_i  (m1_ce_n),
    .m1_oe_n_i  (m1_oe_n),
    .m1_we_n_i  (m1_we_n),
    .m1_addr_i  (m1_addr),
    .m1_dout_i  (m1_dout),
    .ram_ce_n_o (ram_ce_n),
    .pcm_ce_n_o (pcm_ce_n),
    .mem_oe_n_o (mem_oe_n),
    .mem_we_n_o (mem_we_n),
    .mem_addr_o (mem_addr),
    .mem_dout_o (mem_dout)
  );

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed scenarios push expected grant/release/timeout
// events; a monitor pops them as the DUT produces them and also checks the pin mux every cycle.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  localparam int TURN      = 2;
  localparam int HOLD      = 16;
  localparam int SVC_BOUND = HOLD + TURN + 2;

  localparam logic [22:0] A0 = 23'h2ABCDE;
  localparam logic [22:0] A1 = 23'h13579B;
  localparam logic [15:0] D0 = 16'hA5A5;
  localparam logic [15:0] D1 = 16'h5A5A;

  logic clk = 1'b0;
  logic rst_n;
  logic m0_req, m1_req, m0_gnt, m1_gnt;
  logic m0_ce_n, m0_oe_n, m0_we_n, m1_ce_n, m1_oe_n, m1_we_n;
  logic [22:0] m0_addr, m1_addr, mem_addr;
  logic [15:0] m0_dout, m1_dout, mem_dout;
  logic ram_ce_n, pcm_ce_n, mem_oe_n, mem_we_n, timeout;
  logic [1:0] owner;

  mem_bus_arbiter #(.TURN_CYCLES(TURN), .HOLD_MAX(HOLD), .HOLD_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m1_req(m1_req), .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
    .m0_ce_n(m0_ce_n), .m0_oe_n(m0_oe_n), .m0_we_n(m0_we_n), .m0_addr(m0_addr), .m0_dout(m0_dout),
    .m1_ce_n(m1_ce_n), .m1_oe_n(m1_oe_n), .m1_we_n(m1_we_n), .m1_addr(m1_addr), .m1_dout(m1_dout),
    .ram_ce_n(ram_ce_n), .pcm_ce_n(pcm_ce_n), .mem_oe_n(mem_oe_n), .mem_we_n(mem_we_n),
    .mem_addr(mem_addr), .mem_dout(mem_dout), .owner(owner), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int kind; int port; int at; } ev_t;
  ev_t exp_q[$];

  int n_cmp = 0;
  int n_err = 0;
  bit sb_en = 1'b1;
  bit done = 1'b0;
  bit stop_rand = 1'b0;
  logic pg [2];
  int rise_at [2];

  function automatic string kname(input int k);
    case (k)
      0: return "grant";
      1: return "release";
      default: return "timeout";
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h, want %0h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int kind, input int port, input int at);
    ev_t e;
    e.kind = kind; e.port = port; e.at = at;
    exp_q.push_back(e);
  endtask

  task automatic sb_event(input int kind, input int port);
    ev_t e;
    if (!sb_en) return;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL event: unexpected %s port%0d at cyc %0d", kname(kind), port, cyc);
      return;
    end
    e = exp_q.pop_front();
    if (e.kind != kind || e.port != port || e.at != cyc) begin
      n_err++;
      $display("FAIL event: got %s port%0d cyc %0d, want %s port%0d cyc %0d",
               kname(kind), port, cyc, kname(e.kind), e.port, e.at);
    end
  endtask

  function automatic logic [63:0] act_pins();
    return 64'({ram_ce_n, pcm_ce_n, mem_oe_n, mem_we_n, mem_addr, mem_dout});
  endfunction

  function automatic logic [63:0] exp_pins(input logic g0, input logic g1);
    if (g0) return 64'({m0_ce_n, 1'b1, m0_oe_n, m0_we_n, m0_addr, m0_dout});
    if (g1) return 64'({1'b1, m1_ce_n, m1_oe_n, m1_we_n, m1_addr, m1_dout});
    return 64'({4'b1111, 23'd0, 16'd0});
  endfunction

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic monitor();
    logic f0, f1;
    pg[0] = 1'b0; pg[1] = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (done) break;
      if (!rst_n) begin
        pg[0] = 1'b0; pg[1] = 1'b0;
        continue;
      end
      check("gnt_both", 64'(m0_gnt & m1_gnt), 64'd0);
      check("owner_vs_gnt", 64'(owner), 64'({m1_gnt, m0_gnt}));
      check("pins", act_pins(), exp_pins(m0_gnt, m1_gnt));
      f0 = pg[0] && !m0_gnt;
      f1 = pg[1] && !m1_gnt;
      if (f0) begin
        sb_event(1, 0);
        check("hold_len0", 64'(cyc - rise_at[0] <= HOLD), 64'd1);
      end
      if (f1) begin
        sb_event(1, 1);
        check("hold_len1", 64'(cyc - rise_at[1] <= HOLD), 64'd1);
      end
      if (timeout) begin
        sb_event(2, pg[1] ? 1 : 0);
        check("timeout_at_release", 64'(f0 | f1), 64'd1);
      end
      if (!pg[0] && m0_gnt) begin sb_event(0, 0); rise_at[0] = cyc; end
      if (!pg[1] && m1_gnt) begin sb_event(0, 1); rise_at[1] = cyc; end
      pg[0] = m0_gnt;
      pg[1] = m1_gnt;
    end
  endtask

  task automatic set_req(input int p, input logic v);
    if (p == 0) m0_req = v; else m1_req = v;
  endtask

  function automatic logic gnt_of(input int p);
    return (p == 0) ? m0_gnt : m1_gnt;
  endfunction

  task automatic tick_rand(input int p);
    @(posedge clk);
    #1;
    if (p == 0) begin
      {m0_ce_n, m0_oe_n, m0_we_n} = 3'($urandom);
      m0_addr = 23'($urandom); m0_dout = 16'($urandom);
    end else begin
      {m1_ce_n, m1_oe_n, m1_we_n} = 3'($urandom);
      m1_addr = 23'($urandom); m1_dout = 16'($urandom);
    end
  endtask

  task automatic drive_rand(input int p);
    int hold, rq_at, w, ref_at;
    while (!stop_rand) begin
      repeat ($urandom_range(1, 6)) tick_rand(p);
      set_req(p, 1'b1);
      rq_at = cyc;
      w = 0;
      while (!gnt_of(p) && w < 4 * SVC_BOUND && !stop_rand) begin
        tick_rand(p);
        w++;
      end
      if (gnt_of(p)) begin
        ref_at = (rise_at[1-p] > rq_at) ? rise_at[1-p] : rq_at;
        check("svc_latency", 64'(cyc - ref_at <= SVC_BOUND), 64'd1);
        hold = $urandom_range(1, 20);
        while (hold > 0 && gnt_of(p)) begin
          tick_rand(p);
          hold--;
        end
      end else if (!stop_rand) begin
        check("svc_wait_expired", 64'd0, 64'd1);
      end
      set_req(p, 1'b0);
    end
  endtask

  task automatic stimulus();
    int t;
    rst_n = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
    m0_ce_n = 1'b0; m0_oe_n = 1'b0; m0_we_n = 1'b1; m0_addr = A0; m0_dout = D0;
    m1_ce_n = 1'b0; m1_oe_n = 1'b1; m1_we_n = 1'b0; m1_addr = A1; m1_dout = D1;
    wait_cyc(2);
    check("rst_gnt", 64'({m1_gnt, m0_gnt}), 64'd0);
    check("rst_owner", 64'(owner), 64'd0);
    check("rst_timeout", 64'(timeout), 64'd0);
    check("rst_pins", act_pins(), 64'({4'b1111, 23'd0, 16'd0}));
    rst_n = 1'b1;

    // Both requests together out of reset: port 0 first, then port 1 after turnaround.
    wait_cyc(3); t = cyc;
    m0_req = 1'b1; m1_req = 1'b1;
    push(0, 0, t+1); push(1, 0, t+4); push(0, 1, t+7); push(1, 1, t+10);
    wait_cyc(t+3); m0_req = 1'b0;
    for (int i = 4; i <= 6; i++) begin
      wait_cyc(t+i);
      check("turn_oe_we", 64'({mem_oe_n, mem_we_n}), 64'b11);
    end
    wait_cyc(t+9); m1_req = 1'b0;
    wait_cyc(t+12);

    // Port 0 alone for five cycles.
    t = cyc;
    m0_req = 1'b1;
    push(0, 0, t+1); push(1, 0, t+6);
    wait_cyc(t+3);
    check("p0_pins", act_pins(), 64'({1'b0, 1'b1, 1'b0, 1'b1, A0, D0}));
    wait_cyc(t+4);
    m0_ce_n = 1'b1; #1;
    check("ram_ce_follows", 64'({ram_ce_n, pcm_ce_n}), 64'b11);
    m0_ce_n = 1'b0;
    wait_cyc(t+5); m0_req = 1'b0;
    wait_cyc(t+8);

    // Port 0 served last, so a tie now goes to port 1.
    t = cyc;
    m0_req = 1'b1; m1_req = 1'b1;
    push(0, 1, t+1); push(1, 1, t+3); push(0, 0, t+6); push(1, 0, t+7);
    wait_cyc(t+2);
    check("p1_pins", act_pins(), 64'({1'b1, 1'b0, 1'b1, 1'b0, A1, D1}));
    m1_req = 1'b0;
    wait_cyc(t+6); m0_req = 1'b0;
    wait_cyc(t+9);

    // Port 1 asks while port 0 owns: no preemption.
    t = cyc;
    m0_req = 1'b1;
    push(0, 0, t+1); push(1, 0, t+5); push(0, 1, t+8); push(1, 1, t+10);
    wait_cyc(t+2); m1_req = 1'b1;
    wait_cyc(t+4); m0_req = 1'b0;
    wait_cyc(t+9); m1_req = 1'b0;
    wait_cyc(t+12);

    // Hung port 0: revoked after HOLD cycles, blocked until it drops req.
    t = cyc;
    m0_req = 1'b1;
    push(0, 0, t+1); push(1, 0, t+17); push(2, 0, t+17);
    push(0, 1, t+20); push(1, 1, t+25); push(0, 0, t+44); push(1, 0, t+46);
    wait_cyc(t+5); m1_req = 1'b1;
    wait_cyc(t+24); m1_req = 1'b0;
    wait_cyc(t+40); m0_req = 1'b0;
    wait_cyc(t+43); m0_req = 1'b1;
    wait_cyc(t+45); m0_req = 1'b0;
    wait_cyc(t+48);

    // Asynchronous reset in the middle of a port 1 grant.
    t = cyc;
    m1_req = 1'b1;
    push(0, 1, t+1);
    wait_cyc(t+3);
    rst_n = 1'b0; #1;
    check("arst_gnt", 64'({m1_gnt, m0_gnt}), 64'd0);
    check("arst_owner", 64'(owner), 64'd0);
    check("arst_pins", act_pins(), 64'({4'b1111, 23'd0, 16'd0}));
    wait_cyc(t+4);
    rst_n = 1'b1; m0_req = 1'b1;
    push(0, 0, t+5); push(1, 0, t+7); push(0, 1, t+10); push(1, 1, t+12);
    wait_cyc(t+6); m0_req = 1'b0;
    wait_cyc(t+11); m1_req = 1'b0;
    wait_cyc(t+16);
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    // Random well-behaved traffic: invariants and service latency only.
    sb_en = 1'b0;
    t = cyc;
    fork
      drive_rand(0);
      drive_rand(1);
      begin
        wait_cyc(t + 10000);
        stop_rand = 1'b1;
      end
    join
    m0_req = 1'b0; m1_req = 1'b0;
    wait_cyc(cyc + 5);
    done = 1'b1;
  endtask

  initial begin
    rise_at[0] = 0; rise_at[1] = 0;
    fork
      monitor();
      stimulus();
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, cyc %0d", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

endmodule
